play_record_arbiter: RTL and testbench

Owns the on-chip table of the last DEPTH play records and shares it between one writer (game-end page appending a finished play) and NREQ readers (score-history page, result/leaderboard page). It converts the pages' 1-based record IDs (1 = newest) into ring-buffer slots, arbitrates read access round-robin, and gives writes priority. It sits between the page modules and the record storage, under the top-level page mux, on prog_clk.

---
 rtl/play_record_arbiter_pkg.sv | 29 ++
 rtl/play_record_arbiter_if.sv | 36 +++
 rtl/play_record_arbiter_rr_arbiter.sv | 51 +++++
 rtl/play_record_arbiter.sv | 99 +++++++++
 tb/tb_play_record_arbiter.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/play_record_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : play_record_arbiter_pkg
// Purpose  : Shared record type, depth constants and helpers for the play table
// Revision : 1.0
// ============================================================================
package play_record_arbiter_pkg;

  typedef struct packed {
    logic [15:0] score;
    logic [7:0]  level;
    logic [7:0]  lines;
  } PlayRecord;

  localparam int RECORD_DEPTH = 9;
  localparam int COUNT_W      = $clog2(RECORD_DEPTH + 1);

  // IDs travel as raw bytes; the arbiter compares them unsigned so 128..255 miss
  typedef byte RecordId;

  localparam PlayRecord NO_RECORD = '0;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c,
                                                 input int lim);
    return (int'(c) >= lim) ? c : c + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/play_record_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : play_record_arbiter_if
// Purpose  : Page-side bus for the play record table (one writer, NREQ readers)
// Revision : 1.0
// ============================================================================
interface play_record_arbiter_if #(
  parameter int NREQ = 2,
  parameter int CW   = play_record_arbiter_pkg::COUNT_W
);
  import play_record_arbiter_pkg::*;

  logic                     clr;
  logic                     wr_req;
  PlayRecord                wr_data;
  logic                     wr_ack;
  logic [NREQ-1:0]          rd_req;
  logic [NREQ-1:0][7:0]     rd_id;
  logic [NREQ-1:0]          rd_gnt;
  logic [NREQ-1:0]          rd_valid;
  logic                     rd_hit;
  PlayRecord                rd_data;
  logic [CW-1:0]            count;

  modport master (
    output clr, wr_req, wr_data, rd_req, rd_id,
    input  wr_ack, rd_gnt, rd_valid, rd_hit, rd_data, count
  );

  modport slave (
    input  clr, wr_req, wr_data, rd_req, rd_id,
    output wr_ack, rd_gnt, rd_valid, rd_hit, rd_data, count
  );

endinterface
`default_nettype wire

// File: rtl/play_record_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin one-hot arbiter with enable and rotating start pointer
// Revision : 1.0
// ============================================================================
module rr_arbiter
  import play_record_arbiter_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          en,
  input  wire logic [N-1:0]  req,
  output logic      [N-1:0]  gnt,
  output logic      [IW-1:0] gnt_idx,
  output logic               any
);

  logic [IW-1:0] r_ptr;

  function automatic logic [IW-1:0] wrap_idx(input int v);
    return IW'(v % N);
  endfunction

  // Scan from the pointer; the first asserted request wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en && !any && req[wrap_idx(int'(r_ptr) + k)]) begin
        any                                 = 1'b1;
        gnt[wrap_idx(int'(r_ptr) + k)]      = 1'b1;
        gnt_idx                             = wrap_idx(int'(r_ptr) + k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (any) begin
      r_ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/play_record_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : play_record_arbiter
// Purpose  : Ring table of recent play records; write-priority, RR read access
// Revision : 1.0
// ============================================================================
module play_record_arbiter
  import play_record_arbiter_pkg::*;
#(
  parameter int DEPTH = RECORD_DEPTH,
  parameter int NREQ  = 2
) (
  input  wire logic              prog_clk,
  input  wire logic              rst,
  play_record_arbiter_if.slave   bus
);

  localparam int HW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = COUNT_W;
  localparam int SW = CW + 1;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  PlayRecord       r_table [DEPTH];
  logic [HW-1:0]   r_head;
  logic [CW-1:0]   r_count;
  logic [NREQ-1:0] r_valid;
  logic            r_hit;
  PlayRecord       r_data;

  logic            w_wr_go;
  logic            w_rd_en;
  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_any;
  logic [7:0]      w_sel_id;
  logic            w_hit;
  logic [CW-1:0]   w_id_lo;
  logic [SW-1:0]   w_sum;
  logic [HW-1:0]   w_slot;

  // Handshake outputs are combinational, so gate them with reset too
  assign w_wr_go = rst & bus.wr_req & ~bus.clr;
  assign w_rd_en = rst & ~bus.clr & ~bus.wr_req;

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk     (prog_clk),
    .rst_n   (rst),
    .en      (w_rd_en),
    .req     (bus.rd_req),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign w_sel_id = bus.rd_id[w_gnt_idx];
  assign w_hit    = (w_sel_id != 8'd0) && (w_sel_id <= 8'(r_count));
  assign w_id_lo  = w_sel_id[CW-1:0];

  // slot = (head - id + DEPTH) mod DEPTH; only meaningful when w_hit
  assign w_sum  = SW'(r_head) + SW'(DEPTH) - SW'(w_id_lo);
  assign w_slot = (w_sum >= SW'(DEPTH)) ? HW'(w_sum - SW'(DEPTH)) : HW'(w_sum);

  always_ff @(posedge prog_clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_table[i] <= NO_RECORD;
    end else if (bus.clr) begin
      r_head  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_table[i] <= NO_RECORD;
    end else if (w_wr_go) begin
      r_table[r_head] <= bus.wr_data;
      r_head          <= (r_head == HW'(DEPTH - 1)) ? '0 : r_head + 1'b1;
      r_count         <= sat_inc(r_count, DEPTH);
    end
  end

  always_ff @(posedge prog_clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_hit   <= 1'b0;
      r_data  <= NO_RECORD;
    end else begin
      r_valid <= w_gnt;
      r_hit   <= w_any & w_hit;
      r_data  <= (w_any && w_hit) ? r_table[w_slot] : NO_RECORD;
    end
  end

  assign bus.wr_ack   = w_wr_go;
  assign bus.rd_gnt   = w_gnt;
  assign bus.rd_valid = r_valid;
  assign bus.rd_hit   = r_hit;
  assign bus.rd_data  = r_data;
  assign bus.count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_play_record_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_play_record_arbiter
// Purpose  : Directed vector bench for play_record_arbiter
// Revision : 1.0
// ============================================================================
module tb_play_record_arbiter;
  import play_record_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  play_record_arbiter_if #(.NREQ(2)) bus ();

  play_record_arbiter #(.DEPTH(9), .NREQ(2)) dut (
    .prog_clk (clk),
    .rst      (rst),
    .bus      (bus)
  );

  typedef struct {
    logic       clr;
    logic       wr;
    PlayRecord  wd;
    logic [1:0] rq;
    logic [7:0] id0;
    logic [7:0] id1;
    logic       e_ack;
    logic [1:0] e_gnt;
    logic [1:0] e_val;
    logic       e_hit;
    PlayRecord  e_data;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t vt[$];
  int n_run  = 0;
  int n_fail = 0;

  function automatic PlayRecord mk(input int n);
    return PlayRecord'({16'(n * 37 + 5), 8'(n), 8'(255 - n)});
  endfunction

  function automatic void add(input logic c, input logic w, input PlayRecord wd,
                              input logic [1:0] rq, input logic [7:0] i0,
                              input logic [7:0] i1, input logic ack,
                              input logic [1:0] g, input logic [1:0] v,
                              input logic h, input PlayRecord d,
                              input logic [3:0] cnt);
    vec_t x;
    x.clr = c; x.wr = w; x.wd = wd; x.rq = rq; x.id0 = i0; x.id1 = i1;
    x.e_ack = ack; x.e_gnt = g; x.e_val = v; x.e_hit = h; x.e_data = d;
    x.e_cnt = cnt;
    vt.push_back(x);
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.clr = 1'b0; bus.wr_req = 1'b0; bus.wr_data = '0;
    bus.rd_req = '0; bus.rd_id = '0;
  endtask

  initial begin
    PlayRecord z;
    z = '0;
    idle();

    // Table: one entry per cycle; ack/gnt checked before the edge, results after
    add(0,0,z,2'b01,1,0,  0,2'b01,2'b01,0,z,0);
    add(0,1,mk(1),2'b00,0,0, 1,2'b00,2'b00,0,z,1);
    add(0,1,mk(2),2'b00,0,0, 1,2'b00,2'b00,0,z,2);
    add(0,1,mk(3),2'b00,0,0, 1,2'b00,2'b00,0,z,3);
    add(0,0,z,2'b01,1,0,  0,2'b01,2'b01,1,mk(3),3);
    add(0,0,z,2'b01,3,0,  0,2'b01,2'b01,1,mk(1),3);
    add(0,0,z,2'b01,4,0,  0,2'b01,2'b01,0,z,3);
    add(0,0,z,2'b10,0,0,  0,2'b10,2'b10,0,z,3);
    add(0,0,z,2'b10,0,200,0,2'b10,2'b10,0,z,3);
    for (int k = 1; k <= 11; k++)
      add(0,1,mk(100+k),2'b00,0,0, 1,2'b00,2'b00,0,z,4'((3+k > 9) ? 9 : 3+k));
    add(0,0,z,2'b01,1,0,  0,2'b01,2'b01,1,mk(111),9);
    add(0,0,z,2'b01,9,0,  0,2'b01,2'b01,1,mk(103),9);
    add(0,0,z,2'b10,0,10, 0,2'b10,2'b10,0,z,9);
    add(0,0,z,2'b11,1,2,  0,2'b01,2'b01,1,mk(111),9);
    add(0,0,z,2'b11,1,2,  0,2'b10,2'b10,1,mk(110),9);
    add(0,0,z,2'b11,1,2,  0,2'b01,2'b01,1,mk(111),9);
    add(0,0,z,2'b11,1,2,  0,2'b10,2'b10,1,mk(110),9);
    add(0,1,mk(112),2'b01,1,0, 1,2'b00,2'b00,0,z,9);
    add(0,0,z,2'b01,1,0,  0,2'b01,2'b01,1,mk(112),9);
    add(0,0,z,2'b01,0,0,  0,2'b01,2'b01,0,z,9);
    add(1,1,mk(113),2'b01,1,0, 0,2'b00,2'b00,0,z,0);
    add(0,1,mk(113),2'b01,1,0, 1,2'b00,2'b00,0,z,1);
    add(0,0,z,2'b01,1,0,  0,2'b01,2'b01,1,mk(113),1);
    add(0,0,z,2'b01,2,0,  0,2'b01,2'b01,0,z,1);

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_hit", 32'(bus.rd_hit), 32'd0);
    check("rst_data", bus.rd_data, 32'd0);
    check("rst_gnt", 32'(bus.rd_gnt), 32'd0);
    check("rst_ack", 32'(bus.wr_ack), 32'd0);
    #19 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vt.size(); i++) begin
      bus.clr = vt[i].clr; bus.wr_req = vt[i].wr; bus.wr_data = vt[i].wd;
      bus.rd_req = vt[i].rq; bus.rd_id[0] = vt[i].id0; bus.rd_id[1] = vt[i].id1;
      #1;
      check($sformatf("v%0d_ack", i), 32'(bus.wr_ack), 32'(vt[i].e_ack));
      check($sformatf("v%0d_gnt", i), 32'(bus.rd_gnt), 32'(vt[i].e_gnt));
      @(posedge clk); #1;
      check($sformatf("v%0d_valid", i), 32'(bus.rd_valid), 32'(vt[i].e_val));
      check($sformatf("v%0d_hit", i), 32'(bus.rd_hit), 32'(vt[i].e_hit));
      check($sformatf("v%0d_data", i), bus.rd_data, vt[i].e_data);
      check($sformatf("v%0d_count", i), 32'(bus.count), 32'(vt[i].e_cnt));
    end

    // Async reset while a read result is being presented
    idle();
    bus.rd_req = 2'b01; bus.rd_id[0] = 8'd1;
    #1;
    check("mr_gnt", 32'(bus.rd_gnt), 32'b01);
    @(posedge clk); #1;
    check("mr_valid_pre", 32'(bus.rd_valid), 32'b01);
    check("mr_data_pre", bus.rd_data, mk(113));
    bus.wr_req = 1'b1; bus.wr_data = mk(7);
    rst = 1'b0;
    #1;
    check("mr_valid", 32'(bus.rd_valid), 32'd0);
    check("mr_hit", 32'(bus.rd_hit), 32'd0);
    check("mr_data", bus.rd_data, 32'd0);
    check("mr_count", 32'(bus.count), 32'd0);
    check("mr_gnt_rst", 32'(bus.rd_gnt), 32'd0);
    check("mr_ack_rst", 32'(bus.wr_ack), 32'd0);
    @(posedge clk); #1;
    check("mr_valid_hold", 32'(bus.rd_valid), 32'd0);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_count", 32'(bus.count), 32'd0);
    check("post_valid", 32'(bus.rd_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
